// File: rtl/alg_awb_iir_pkg.sv
// Shared definitions for the AWB gain engine: FSM encoding, iir_shift width
// and the unity-gain helper.
package alg_awb_iir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIV_R  = 2'd1,
      ST_DIV_B  = 2'd2,
      ST_UPDATE = 2'd3
   } awb_state_e;

   localparam int IIR_SHIFT_W = 3;

   // Unity gain in a fixed-point format with the given number of fraction bits.
   function automatic int unity_gain(input int frac);
      return 1 << frac;
   endfunction

endpackage

// File: rtl/alg_awb_iir_seq_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, NUM_W cycles
// per division. The final quotient is presented combinationally in the cycle
// where done is high, so a new division may be started on that same edge.
module alg_awb_iir_seq_div #(
   parameter int NUM_W = 36,
   parameter int DEN_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             done,
   output logic [NUM_W-1:0] quot,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] r_num;     // numerator bits shift out, quotient bits shift in
   logic [DEN_W-1:0] r_rem;
   logic [DEN_W-1:0] r_den;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dz;

   logic [DEN_W:0]   w_trial;
   logic [DEN_W:0]   w_diff;
   logic             w_ge;
   logic [DEN_W-1:0] w_rem_nxt;
   logic [NUM_W-1:0] w_num_nxt;

   // One restoring iteration: bring down the next numerator bit and try a subtract.
   always_comb begin
      w_trial   = {r_rem, r_num[NUM_W-1]};
      w_diff    = w_trial - {1'b0, r_den};
      w_ge      = (w_trial >= {1'b0, r_den});
      w_rem_nxt = w_ge ? w_diff[DEN_W-1:0] : w_trial[DEN_W-1:0];
      w_num_nxt = {r_num[NUM_W-2:0], w_ge};
   end

   assign done     = (r_cnt == CNT_W'(1));
   assign quot     = w_num_nxt;
   assign div_zero = r_dz;

   // Iteration counter and divide-by-zero flag; start always wins over a running division.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_dz  <= 1'b0;
      end else if (start) begin
         r_cnt <= CNT_W'(NUM_W);
         r_dz  <= (den == '0);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Datapath registers: load operands on start, otherwise iterate while counting.
   always_ff @(posedge clk) begin
      if (start) begin
         r_num <= num;
         r_rem <= '0;
         r_den <= den;
      end else if (r_cnt != '0) begin
         r_num <= w_num_nxt;
         r_rem <= w_rem_nxt;
      end
   end

endmodule

// File: rtl/alg_awb_iir.sv
// AWB gain engine: per-frame R/G/B sums are turned into R and B gains that
// equalise those channels to G, via one shared sequential divider, clamping,
// IIR temporal smoothing and a manual override.
module alg_awb_iir
   import alg_awb_iir_pkg::*;
#(
   parameter int STAT_W   = 32,
   parameter int GAIN_W   = 8,
   parameter int FRAC     = 4,
   parameter int GAIN_MIN = 4,
   parameter int GAIN_MAX = 255,
   parameter int MIN_PIX  = 1024
) (
   input  logic                   pclk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   manual,
   input  logic [GAIN_W-1:0]      man_r_gain,
   input  logic [GAIN_W-1:0]      man_b_gain,
   input  logic [IIR_SHIFT_W-1:0] iir_shift,
   input  logic                   stat_done,
   input  logic [STAT_W-1:0]      pix_cnt,
   input  logic [STAT_W-1:0]      sum_r,
   input  logic [STAT_W-1:0]      sum_g,
   input  logic [STAT_W-1:0]      sum_b,
   output logic [GAIN_W-1:0]      r_gain,
   output logic [GAIN_W-1:0]      g_gain,
   output logic [GAIN_W-1:0]      b_gain,
   output logic                   busy,
   output logic                   gain_valid
);

   localparam int Q  = STAT_W + FRAC;
   localparam int SW = GAIN_W + 2;
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(FRAC));

   awb_state_e        r_state;
   logic [STAT_W-1:0] r_sum_g;
   logic [STAT_W-1:0] r_sum_b;
   logic [GAIN_W-1:0] r_rgain;
   logic [GAIN_W-1:0] r_bgain;
   logic [GAIN_W-1:0] r_tgt_r;
   logic [GAIN_W-1:0] r_tgt_b;
   logic              r_busy;
   logic              r_gvld;

   logic              w_accept;
   logic              w_div_start;
   logic [Q-1:0]      w_div_num;
   logic [STAT_W-1:0] w_div_den;
   logic              w_div_done;
   logic [Q-1:0]      w_quot;
   logic              w_div_zero;

   // Raw quotient to target gain; a zero divisor means the channel is dark, so max gain.
   function automatic logic [GAIN_W-1:0] clamp_quot(input logic [Q-1:0] q, input logic dz);
      if (dz || (q > Q'(GAIN_MAX)))
         return GAIN_W'(GAIN_MAX);
      else if (q < Q'(GAIN_MIN))
         return GAIN_W'(GAIN_MIN);
      else
         return q[GAIN_W-1:0];
   endfunction

   // One smoothing step toward the target: round-to-nearest arithmetic shift of the
   // error, never stalling short of the target, result kept inside the clamp range
   // (the current value may come from the manual path and lie outside it).
   function automatic logic [GAIN_W-1:0] iir_step(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt,
                                                  input logic [IIR_SHIFT_W-1:0] k);
      logic signed [SW-1:0] d;
      logic signed [SW-1:0] rnd;
      logic signed [SW-1:0] step;
      logic signed [SW-1:0] nxt;
      d   = $signed({2'b00, tgt}) - $signed({2'b00, cur});
      rnd = '0;
      if (k != '0)
         rnd = $signed(SW'(1) << (k - IIR_SHIFT_W'(1)));
      step = (d + rnd) >>> k;
      if ((d != '0) && (step == '0))
         step = d[SW-1] ? $signed({SW{1'b1}}) : $signed(SW'(1));
      nxt = $signed({2'b00, cur}) + step;
      if (nxt > $signed(SW'(GAIN_MAX)))
         nxt = $signed(SW'(GAIN_MAX));
      else if (nxt < $signed(SW'(GAIN_MIN)))
         nxt = $signed(SW'(GAIN_MIN));
      return nxt[GAIN_W-1:0];
   endfunction

   assign w_accept = (r_state == ST_IDLE) && stat_done && enable && !manual &&
                     (pix_cnt >= STAT_W'(MIN_PIX));

   // R division reads the live inputs on acceptance; B division reads the latched copy.
   assign w_div_start = !manual && (w_accept || ((r_state == ST_DIV_R) && w_div_done));
   assign w_div_num   = (r_state == ST_IDLE) ? {sum_g, {FRAC{1'b0}}} : {r_sum_g, {FRAC{1'b0}}};
   assign w_div_den   = (r_state == ST_IDLE) ? sum_r : r_sum_b;

   alg_awb_iir_seq_div #(
      .NUM_W (Q),
      .DEN_W (STAT_W)
   ) u_div (
      .clk      (pclk),
      .rst      (rst),
      .start    (w_div_start),
      .num      (w_div_num),
      .den      (w_div_den),
      .done     (w_div_done),
      .quot     (w_quot),
      .div_zero (w_div_zero)
   );

   // Frame sums and clamped targets; only meaningful while a computation is in flight.
   always_ff @(posedge pclk) begin
      if (w_accept) begin
         r_sum_g <= sum_g;
         r_sum_b <= sum_b;
      end
      if ((r_state == ST_DIV_R) && w_div_done)
         r_tgt_r <= clamp_quot(w_quot, w_div_zero);
      if ((r_state == ST_DIV_B) && w_div_done)
         r_tgt_b <= clamp_quot(w_quot, w_div_zero);
   end

   // Control FSM with registered gains; manual override aborts any computation.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_gvld  <= 1'b0;
         r_rgain <= UNITY;
         r_bgain <= UNITY;
      end else begin
         r_gvld <= 1'b0;
         if (manual) begin
            r_rgain <= man_r_gain;
            r_bgain <= man_b_gain;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_state <= ST_DIV_R;
                     r_busy  <= 1'b1;
                  end
               end
               ST_DIV_R: begin
                  if (w_div_done)
                     r_state <= ST_DIV_B;
               end
               ST_DIV_B: begin
                  if (w_div_done)
                     r_state <= ST_UPDATE;
               end
               ST_UPDATE: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  if (enable) begin
                     r_rgain <= iir_step(r_rgain, r_tgt_r, iir_shift);
                     r_bgain <= iir_step(r_bgain, r_tgt_b, iir_shift);
                     r_gvld  <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign r_gain     = r_rgain;
   assign g_gain     = UNITY;
   assign b_gain     = r_bgain;
   assign busy       = r_busy;
   assign gain_valid = r_gvld;

endmodule

// File: tb/tb_alg_awb_iir.sv
// Directed bench for alg_awb_iir: reset state, latency, IIR convergence,
// clamp/gate boundaries, and the multi-cycle corner cases.
module tb_alg_awb_iir;

   logic        pclk;
   logic        rst;
   logic        enable;
   logic        manual;
   logic [7:0]  man_r_gain;
   logic [7:0]  man_b_gain;
   logic [2:0]  iir_shift;
   logic        stat_done;
   logic [31:0] pix_cnt;
   logic [31:0] sum_r;
   logic [31:0] sum_g;
   logic [31:0] sum_b;
   logic [7:0]  r_gain;
   logic [7:0]  g_gain;
   logic [7:0]  b_gain;
   logic        busy;
   logic        gain_valid;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] sr;
      logic [31:0] sg;
      logic [31:0] sb;
      logic [31:0] pix;
      logic [2:0]  k;
      logic        exp_vld;
      logic [7:0]  exp_r;
      logic [7:0]  exp_b;
   } vec_t;

   vec_t tbl[13];

   alg_awb_iir dut (
      .pclk       (pclk),
      .rst        (rst),
      .enable     (enable),
      .manual     (manual),
      .man_r_gain (man_r_gain),
      .man_b_gain (man_b_gain),
      .iir_shift  (iir_shift),
      .stat_done  (stat_done),
      .pix_cnt    (pix_cnt),
      .sum_r      (sum_r),
      .sum_g      (sum_g),
      .sum_b      (sum_b),
      .r_gain     (r_gain),
      .g_gain     (g_gain),
      .b_gain     (b_gain),
      .busy       (busy),
      .gain_valid (gain_valid)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic drive_sums(input logic [31:0] sr, input logic [31:0] sg,
                             input logic [31:0] sb, input logic [31:0] pix,
                             input logic [2:0] k);
      sum_r     = sr;
      sum_g     = sg;
      sum_b     = sb;
      pix_cnt   = pix;
      iir_shift = k;
   endtask

   // Pulse stat_done for one cycle and watch maxc edges; reports pulses and first latency.
   task automatic run_frame(input logic [31:0] sr, input logic [31:0] sg,
                            input logic [31:0] sb, input logic [31:0] pix,
                            input logic [2:0] k, input int maxc,
                            output int npulse, output int lat);
      @(negedge pclk);
      drive_sums(sr, sg, sb, pix, k);
      stat_done = 1'b1;
      npulse = 0;
      lat = -1;
      for (int c = 1; c <= maxc; c++) begin
         @(posedge pclk);
         @(negedge pclk);
         stat_done = 1'b0;
         if (gain_valid) begin
            if (npulse == 0) lat = c;
            npulse++;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      rst = 1'b0;
   endtask

   initial begin
      int np;
      int lat;
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      enable     = 1'b1;
      manual     = 1'b0;
      man_r_gain = 8'd0;
      man_b_gain = 8'd0;
      stat_done  = 1'b0;
      drive_sums(32'd0, 32'd0, 32'd0, 32'd0, 3'd0);

      // k=2 convergence from 16 toward R target 32 and B target 8, then clamp/gate rows.
      tbl[0]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd20,  8'd14};
      tbl[1]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd23,  8'd13};
      tbl[2]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd25,  8'd12};
      tbl[3]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd27,  8'd11};
      tbl[4]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd28,  8'd10};
      tbl[5]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd29,  8'd9};
      tbl[6]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd30,  8'd8};
      tbl[7]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd31,  8'd8};
      tbl[8]  = '{32'd800, 32'd1600, 32'd3200,  32'd4096, 3'd2, 1'b1, 8'd32,  8'd8};
      tbl[9]  = '{32'd0,   32'd1600, 32'd20000, 32'd4096, 3'd0, 1'b1, 8'd255, 8'd4};
      tbl[10] = '{32'd800, 32'd1600, 32'd3200,  32'd100,  3'd0, 1'b0, 8'd255, 8'd4};
      tbl[11] = '{32'd800, 32'd1600, 32'd3200,  32'd1024, 3'd0, 1'b1, 8'd32,  8'd8};
      tbl[12] = '{32'd0,   32'd1600, 32'd20000, 32'd1023, 3'd0, 1'b0, 8'd32,  8'd8};

      // Reset state.
      @(negedge pclk);
      @(negedge pclk);
      check("rst_r_gain", int'(r_gain), 16);
      check("rst_g_gain", int'(g_gain), 16);
      check("rst_b_gain", int'(b_gain), 16);
      check("rst_busy", int'(busy), 0);
      check("rst_gain_valid", int'(gain_valid), 0);
      rst = 1'b0;
      repeat (8) @(negedge pclk);
      check("idle_r_gain", int'(r_gain), 16);
      check("idle_b_gain", int'(b_gain), 16);

      // Unsmoothed frame: latency and direct ratio.
      run_frame(32'd800, 32'd1600, 32'd3200, 32'd4096, 3'd0, 90, np, lat);
      check("k0_pulses", np, 1);
      check("k0_latency", lat, 74);
      check("k0_r_gain", int'(r_gain), 32);
      check("k0_b_gain", int'(b_gain), 8);
      check("k0_busy_after", int'(busy), 0);

      // Table-driven frames from a fresh reset.
      pulse_reset();
      for (int i = 0; i < 13; i++) begin
         run_frame(tbl[i].sr, tbl[i].sg, tbl[i].sb, tbl[i].pix, tbl[i].k, 80, np, lat);
         check($sformatf("tbl%0d_pulses", i), np, int'(tbl[i].exp_vld));
         if (tbl[i].exp_vld)
            check($sformatf("tbl%0d_latency", i), lat, 74);
         check($sformatf("tbl%0d_r_gain", i), int'(r_gain), int'(tbl[i].exp_r));
         check($sformatf("tbl%0d_b_gain", i), int'(b_gain), int'(tbl[i].exp_b));
      end

      // Second stat_done during a computation is ignored; first frame's result wins.
      @(negedge pclk);
      drive_sums(32'd400, 32'd1600, 32'd1600, 32'd4096, 3'd0);
      stat_done = 1'b1;
      np = 0;
      lat = -1;
      for (int c = 1; c <= 160; c++) begin
         @(posedge pclk);
         @(negedge pclk);
         stat_done = 1'b0;
         if (gain_valid) begin
            if (np == 0) lat = c;
            np++;
         end
         if (c == 1) check("second_busy_set", int'(busy), 1);
         if (c == 10) begin
            drive_sums(32'd3200, 32'd1600, 32'd800, 32'd4096, 3'd0);
            stat_done = 1'b1;
         end
      end
      check("second_pulses", np, 1);
      check("second_latency", lat, 74);
      check("second_r_gain", int'(r_gain), 64);
      check("second_b_gain", int'(b_gain), 16);

      // Manual override mid-computation aborts without a gain_valid.
      @(negedge pclk);
      drive_sums(32'd800, 32'd1600, 32'd3200, 32'd4096, 3'd0);
      stat_done = 1'b1;
      np = 0;
      for (int c = 1; c <= 120; c++) begin
         @(posedge pclk);
         @(negedge pclk);
         stat_done = 1'b0;
         if (gain_valid) np++;
         if (c == 30) begin
            manual     = 1'b1;
            man_r_gain = 8'd40;
            man_b_gain = 8'd50;
         end
         if (c == 31) begin
            check("manual_r_gain", int'(r_gain), 40);
            check("manual_b_gain", int'(b_gain), 50);
            check("manual_busy", int'(busy), 0);
         end
         if (c == 33) manual = 1'b0;
      end
      check("manual_pulses", np, 0);
      check("manual_r_hold", int'(r_gain), 40);

      // Auto path resumes from the manual values (k=1 toward 32 and 8).
      run_frame(32'd800, 32'd1600, 32'd3200, 32'd4096, 3'd1, 80, np, lat);
      check("resume_pulses", np, 1);
      check("resume_r_gain", int'(r_gain), 36);
      check("resume_b_gain", int'(b_gain), 29);

      // enable dropped mid-computation: completes silently, gains hold.
      @(negedge pclk);
      drive_sums(32'd400, 32'd1600, 32'd1600, 32'd4096, 3'd0);
      stat_done = 1'b1;
      np = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge pclk);
         @(negedge pclk);
         stat_done = 1'b0;
         if (gain_valid) np++;
         if (c == 20) enable = 1'b0;
      end
      check("disable_pulses", np, 0);
      check("disable_busy", int'(busy), 0);
      check("disable_r_gain", int'(r_gain), 36);
      check("disable_b_gain", int'(b_gain), 29);
      enable = 1'b1;

      // Asynchronous reset during the B division.
      @(negedge pclk);
      drive_sums(32'd400, 32'd1600, 32'd1600, 32'd4096, 3'd0);
      stat_done = 1'b1;
      np = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge pclk);
         @(negedge pclk);
         stat_done = 1'b0;
         if (gain_valid) np++;
         if (c == 50) begin
            check("midb_busy_before", int'(busy), 1);
            rst = 1'b1;
            #1;
            check("midb_rst_r_gain", int'(r_gain), 16);
            check("midb_rst_b_gain", int'(b_gain), 16);
            check("midb_rst_busy", int'(busy), 0);
         end
         if (c == 51) rst = 1'b0;
      end
      check("midb_pulses", np, 0);
      check("midb_r_after", int'(r_gain), 16);
      check("midb_g_after", int'(g_gain), 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
